dma: RTL

Single-channel word-copy DMA engine. It occupies bus master slot 2 (m2) and bus slave slot 5 (s5) of the chip, both of which are currently tied off. The CPU programs source, destination and count through the slave port. The engine then copies words over the shared bus, one read beat and one write beat per word, and raises an interrupt when the copy completes.

---
 rtl/dma.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/dma.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dma                                                       |
// | Purpose  : Single-channel word-copy DMA engine. The CPU programs     |
// |            SRC/DST/COUNT through the slave port; the engine copies   |
// |            one word per read beat + write beat pair over the shared  |
// |            bus and raises a level interrupt on completion.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module dma (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_cs_,
  input  logic        s_as_,
  input  logic        s_rw,
  input  logic [1:0]  s_addr,
  input  logic [31:0] s_wr_data,
  output logic [31:0] s_rd_data,
  output logic        s_rdy_,
  output logic        m_req_,
  input  logic        m_grnt_,
  output logic [29:0] m_addr,
  output logic        m_as_,
  output logic        m_rw,
  output logic [31:0] m_wr_data,
  input  logic [31:0] m_rd_data,
  input  logic        m_rdy_,
  output logic        irq
);

  localparam logic       RW_READ   = 1'b1;
  localparam logic       RW_WRITE  = 1'b0;
  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_SRC   = 2'd1;
  localparam logic [1:0] REG_DST   = 2'd2;
  localparam logic [1:0] REG_COUNT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  state_t      state_q;
  logic [29:0] src_q;
  logic [29:0] dst_q;
  logic [15:0] count_q;
  logic        ie_q;
  logic        done_q;
  logic        abort_pend_q;
  logic        m_req_q;
  logic        m_as_q;
  logic        m_rw_q;
  logic [29:0] m_addr_q;
  logic [31:0] m_wr_data_q;   // also serves as the read-to-write data buffer
  logic        s_rdy_q;
  logic [31:0] s_rd_data_q;

  logic        s_acc_d;
  logic        s_wr_d;
  logic        ctrl_wr_d;
  logic        busy_d;
  logic        start_d;
  logic        abort_d;
  logic [31:0] rd_mux_d;
  logic        unused_wdata;

  // A new access is accepted only while no response is pending, so a
  // strobe held across the ready cycle does not produce a second response.
  assign s_acc_d   = ~s_cs_ & ~s_as_ & s_rdy_q;
  assign s_wr_d    = s_acc_d & ~s_rw;
  assign ctrl_wr_d = s_wr_d & (s_addr == REG_CTRL);
  assign busy_d    = (state_q != ST_IDLE);
  assign start_d   = ctrl_wr_d & s_wr_data[0] & ~busy_d;
  assign abort_d   = ctrl_wr_d & s_wr_data[2] & busy_d;
  assign unused_wdata = ^s_wr_data[31:30];

  // Register read-back multiplexer
  always_comb begin
    rd_mux_d = 32'h0;
    case (s_addr)
      REG_CTRL:  rd_mux_d = {28'h0, done_q, 1'b0, ie_q, busy_d};
      REG_SRC:   rd_mux_d = {2'b00, src_q};
      REG_DST:   rd_mux_d = {2'b00, dst_q};
      REG_COUNT: rd_mux_d = {16'h0, count_q};
      default:   rd_mux_d = 32'h0;
    endcase
  end

  // Slave response: one-cycle ready pulse, read data valid only with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_rdy_q     <= 1'b1;
      s_rd_data_q <= 32'h0;
    end else if (s_acc_d) begin
      s_rdy_q     <= 1'b0;
      s_rd_data_q <= s_rw ? rd_mux_d : 32'h0;
    end else begin
      s_rdy_q     <= 1'b1;
      s_rd_data_q <= 32'h0;
    end
  end

  // Config registers, copy FSM and registered master outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      src_q        <= 30'h0;
      dst_q        <= 30'h0;
      count_q      <= 16'h0;
      ie_q         <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      m_req_q      <= 1'b1;
      m_as_q       <= 1'b1;
      m_rw_q       <= RW_READ;
      m_addr_q     <= 30'h0;
      m_wr_data_q  <= 32'h0;
    end else begin
      if (ctrl_wr_d) begin
        ie_q <= s_wr_data[1];
        if (s_wr_data[3]) done_q <= 1'b0;
      end
      // Transfer parameters are frozen while a copy is in flight
      if (s_wr_d && !busy_d) begin
        case (s_addr)
          REG_SRC:   src_q   <= s_wr_data[29:0];
          REG_DST:   dst_q   <= s_wr_data[29:0];
          REG_COUNT: count_q <= s_wr_data[15:0];
          default:   ;
        endcase
      end

      case (state_q)
        ST_IDLE: begin
          abort_pend_q <= 1'b0;
          if (start_d) begin
            if (count_q == 16'h0) begin
              done_q <= 1'b1;
            end else begin
              done_q  <= 1'b0;
              state_q <= ST_REQ;
              m_req_q <= 1'b0;
            end
          end
        end
        ST_REQ: begin
          if (abort_d) begin
            state_q <= ST_IDLE;
            m_req_q <= 1'b1;
          end else if (!m_grnt_) begin
            state_q  <= ST_RD;
            m_as_q   <= 1'b0;
            m_rw_q   <= RW_READ;
            m_addr_q <= src_q;
          end
        end
        ST_RD: begin
          if (!m_rdy_) begin
            if (abort_d || abort_pend_q) begin
              // Read beat finished; drop the word without writing it
              state_q  <= ST_IDLE;
              m_req_q  <= 1'b1;
              m_as_q   <= 1'b1;
              m_addr_q <= 30'h0;
            end else begin
              state_q     <= ST_WR;
              m_rw_q      <= RW_WRITE;
              m_addr_q    <= dst_q;
              m_wr_data_q <= m_rd_data;
            end
          end else if (abort_d) begin
            abort_pend_q <= 1'b1;
          end
        end
        ST_WR: begin
          if (!m_rdy_) begin
            src_q       <= src_q + 30'd1;
            dst_q       <= dst_q + 30'd1;
            count_q     <= count_q - 16'd1;
            m_req_q     <= 1'b1;
            m_as_q      <= 1'b1;
            m_rw_q      <= RW_READ;
            m_addr_q    <= 30'h0;
            m_wr_data_q <= 32'h0;
            state_q     <= (abort_d || abort_pend_q) ? ST_IDLE : ST_GAP;
          end else if (abort_d) begin
            abort_pend_q <= 1'b1;
          end
        end
        ST_GAP: begin
          // One released cycle between words lets the arbiter serve the CPU
          if (abort_d) begin
            state_q <= ST_IDLE;
          end else if (count_q == 16'h0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_REQ;
            m_req_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          m_req_q <= 1'b1;
          m_as_q  <= 1'b1;
        end
      endcase
    end
  end

  assign s_rdy_    = s_rdy_q;
  assign s_rd_data = s_rd_data_q;
  assign m_req_    = m_req_q;
  assign m_as_     = m_as_q;
  assign m_rw      = m_rw_q;
  assign m_addr    = m_addr_q;
  assign m_wr_data = m_wr_data_q;
  assign irq       = done_q & ie_q;

endmodule
`default_nettype wire
